// File: rtl/hs32_bram_arb_pkg.sv
// Shared types and constants for the HS32 BRAM arbiter slice.
package hs32_bram_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam int NUM_PORTS      = 2;
  localparam int PORT_CPU       = 0;
  localparam int PORT_WB        = 1;
  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_TIMEOUT    = 15;
endpackage

// File: rtl/hs32_bram_arb_if.sv
// Requester-side bus (CPU / wishbone bridge) and controller-side bus.
interface hs32_bram_arb_if #(parameter int ADDR_WIDTH = 12);
  logic                  stb;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           dwrite;
  logic                  rw;
  logic                  ack;
  logic [31:0]           dread;
  logic                  err;
  logic                  ovf;

  modport master (output stb, addr, dwrite, rw, input  ack, dread, err, ovf);
  modport slave  (input  stb, addr, dwrite, rw, output ack, dread, err, ovf);
endinterface

interface hs32_bram_mem_if #(parameter int ADDR_WIDTH = 12);
  logic                  stb;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           dwrite;
  logic                  rw;
  logic                  ack;
  logic [31:0]           dread;

  modport master (output stb, addr, dwrite, rw, input  ack, dread);
  modport slave  (input  stb, addr, dwrite, rw, output ack, dread);
endinterface

// File: rtl/hs32_bram_req_buf.sv
// One-deep request latch for a single requester, with overflow pulse.
module hs32_bram_req_buf #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  stb,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           dwrite,
  input  logic                  rw,
  input  logic                  clr,
  output logic                  pend,
  output logic [ADDR_WIDTH-1:0] addr_q,
  output logic [31:0]           dwrite_q,
  output logic                  rw_q,
  output logic                  ovf
);
  // A strobe in the ack cycle is accepted since pend drops on that same edge.
  logic load;
  assign load = stb && (!pend || clr);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pend     <= 1'b0;
      addr_q   <= '0;
      dwrite_q <= '0;
      rw_q     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      ovf <= stb && pend && !clr;
      if (load) begin
        pend     <= 1'b1;
        addr_q   <= addr;
        dwrite_q <= dwrite;
        rw_q     <= rw;
      end else if (clr) begin
        pend <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/hs32_bram_arb.sv
// Round-robin arbiter sharing the BRAM controller between CPU and wishbone bridge.
module hs32_bram_arb
  import hs32_bram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic             i_clk,
  input  logic             i_reset,
  hs32_bram_arb_if.slave   cpu,
  hs32_bram_arb_if.slave   wb,
  hs32_bram_mem_if.master  mem
);
  localparam int              CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   TMAX = CW'(TIMEOUT);

  logic [NUM_PORTS-1:0]                 stb, rw_in, pend, clr, ovf, err, rw_q;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] addr_in, addr_q;
  logic [NUM_PORTS-1:0][31:0]           dw_in, dw_q, dread_q;

  assign stb[PORT_CPU]     = cpu.stb;
  assign stb[PORT_WB]      = wb.stb;
  assign addr_in[PORT_CPU] = cpu.addr;
  assign addr_in[PORT_WB]  = wb.addr;
  assign dw_in[PORT_CPU]   = cpu.dwrite;
  assign dw_in[PORT_WB]    = wb.dwrite;
  assign rw_in[PORT_CPU]   = cpu.rw;
  assign rw_in[PORT_WB]    = wb.rw;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_buf
    hs32_bram_req_buf #(.ADDR_WIDTH(ADDR_WIDTH)) u_buf (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .stb      (stb[p]),
      .addr     (addr_in[p]),
      .dwrite   (dw_in[p]),
      .rw       (rw_in[p]),
      .clr      (clr[p]),
      .pend     (pend[p]),
      .addr_q   (addr_q[p]),
      .dwrite_q (dw_q[p]),
      .rw_q     (rw_q[p]),
      .ovf      (ovf[p])
    );
  end

  state_t        state, state_nx;
  logic          grant, grant_nx, last_grant, last_grant_nx;
  logic          timed_out, timed_out_nx;
  logic [CW-1:0] cnt, cnt_nx, cnt_inc;
  logic          cap;
  logic [31:0]   cap_val;

  assign cnt_inc = cnt + CW'(1);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      timed_out  <= 1'b0;
      cnt        <= '0;
      dread_q    <= '0;
    end else begin
      state      <= state_nx;
      grant      <= grant_nx;
      last_grant <= last_grant_nx;
      timed_out  <= timed_out_nx;
      cnt        <= cnt_nx;
      if (cap) dread_q[grant] <= cap_val;
    end
  end

  always_comb begin
    state_nx      = state;
    grant_nx      = grant;
    last_grant_nx = last_grant;
    timed_out_nx  = timed_out;
    cnt_nx        = cnt;
    cap           = 1'b0;
    cap_val       = '0;
    case (state)
      IDLE: if (|pend) begin
        state_nx = ISSUE;
        // last_grant only moves on a tie, so alternation is between contended pairs
        if (&pend) begin
          grant_nx      = ~last_grant;
          last_grant_nx = ~last_grant;
        end else begin
          grant_nx = pend[PORT_WB];
        end
      end
      ISSUE: begin
        cnt_nx       = '0;
        timed_out_nx = 1'b0;
        state_nx     = WAIT;
      end
      WAIT: begin
        if (mem.ack) begin
          cap      = 1'b1;
          cap_val  = mem.dread;
          state_nx = DONE;
        end else begin
          cnt_nx = cnt_inc;
          if (cnt_inc == TMAX) begin
            cap          = 1'b1;
            timed_out_nx = 1'b1;
            state_nx     = DONE;
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    clr = '0;
    if (state == DONE) clr[grant] = 1'b1;
    err = timed_out ? clr : '0;
  end

  logic on_bus, sel;
  assign on_bus     = (state == ISSUE) || (state == WAIT);
  assign sel        = on_bus ? grant : 1'(PORT_CPU);
  assign mem.stb    = (state == ISSUE);
  assign mem.addr   = addr_q[sel];
  assign mem.dwrite = dw_q[sel];
  assign mem.rw     = rw_q[sel];

  assign cpu.ack   = clr[PORT_CPU];
  assign wb.ack    = clr[PORT_WB];
  assign cpu.err   = err[PORT_CPU];
  assign wb.err    = err[PORT_WB];
  assign cpu.ovf   = ovf[PORT_CPU];
  assign wb.ovf    = ovf[PORT_WB];
  assign cpu.dread = dread_q[PORT_CPU];
  assign wb.dread  = dread_q[PORT_WB];
endmodule

// File: tb/tb_hs32_bram_arb.sv
// Directed and randomized checks of hs32_bram_arb against a cycle-rule reference model.
module tb_hs32_bram_arb;
  import hs32_bram_pkg::*;
  localparam int AW = 12;

  logic i_clk   = 1'b0;
  logic i_reset = 1'b1;
  always #5 i_clk = ~i_clk;

  hs32_bram_arb_if #(.ADDR_WIDTH(AW)) cpu ();
  hs32_bram_arb_if #(.ADDR_WIDTH(AW)) wb ();
  hs32_bram_mem_if #(.ADDR_WIDTH(AW)) mem ();

  hs32_bram_arb #(.ADDR_WIDTH(AW), .TIMEOUT(15)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .cpu(cpu), .wb(wb), .mem(mem)
  );

  logic [31:0] mem_arr [0:(1<<AW)-1];
  assign mem.dread = mem_arr[mem.addr];

  int checks = 0, failures = 0;
  int cyc = 0;

  // request model: one buffered request per port
  logic          m_pend [2];
  int            m_acc  [2];
  logic [AW-1:0] m_addr [2];
  logic [31:0]   m_dw   [2];
  logic          m_rw   [2];
  logic          tie_last;
  int            last_ack;
  bit            infl, exp_err;
  int            infl_p, s_cyc, ack_at, oack_at;
  logic [31:0]   exp_dread [2];
  logic          exp_ovf   [2];
  // controller model
  int            ctl_mode, ctl_d;
  bit            noise;
  bit            wr_pend;
  logic [AW-1:0] wr_a;
  logic [31:0]   wr_d;
  // stimulus for next step
  logic          r_stb  [2];
  logic [AW-1:0] r_addr [2];
  logic [31:0]   r_dw   [2];
  logic          r_rw   [2];
  bit            restrobe0;
  logic [AW-1:0] rs_addr;
  // observed event cycles
  int            obs_stb;
  int            obs_ack [2];
  int            obs_err [2];
  int            t0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int p, input logic [AW-1:0] a, input logic [31:0] d, input logic rw);
    r_stb[p] = 1'b1; r_addr[p] = a; r_dw[p] = d; r_rw[p] = rw;
  endtask

  task automatic model_clear();
    for (int p = 0; p < 2; p++) begin
      m_pend[p] = 0; m_acc[p] = 0; exp_dread[p] = '0; exp_ovf[p] = 0;
      r_stb[p] = 0; obs_ack[p] = -1; obs_err[p] = -1;
    end
    tie_last = 1'b1; last_ack = -100; infl = 0; wr_pend = 0; obs_stb = -1;
  endtask

  task automatic do_reset();
    i_reset = 1'b1; cpu.stb = 0; wb.stb = 0; mem.ack = 0;
    model_clear();
    @(negedge i_clk); cyc++;
    chk("rst_stb", 32'(mem.stb), 0);
    chk("rst_addr", 32'(mem.addr), 0);
    chk("rst_dwrite", mem.dwrite, 0);
    chk("rst_rw", 32'(mem.rw), 0);
    chk("rst_ack", {30'd0, wb.ack, cpu.ack}, 0);
    chk("rst_err", {30'd0, wb.err, cpu.err}, 0);
    chk("rst_ovf", {30'd0, wb.ovf, cpu.ovf}, 0);
    chk("rst_dread0", cpu.dread, 0);
    chk("rst_dread1", wb.dread, 0);
    i_reset = 1'b0;
  endtask

  task automatic step();
    bit e0, e1, es, eack, wait_cyc, ackv;
    int g, d;
    logic        o_ack [2], o_err [2], o_ovf [2];
    logic [31:0] o_dr  [2];
    @(negedge i_clk); cyc++;
    if (wr_pend) begin mem_arr[wr_a] = wr_d; wr_pend = 0; end
    // a request can issue two cycles after buffering and two after the previous ack
    e0 = m_pend[0] && (m_acc[0] <= cyc - 2);
    e1 = m_pend[1] && (m_acc[1] <= cyc - 2);
    es = !infl && (cyc >= last_ack + 2) && (e0 || e1);
    chk("stb", 32'(mem.stb), 32'(es));
    if (mem.stb) obs_stb = cyc;
    if (es) begin
      g = (e0 && e1) ? (tie_last ? 0 : 1) : (e0 ? 0 : 1);
      if (e0 && e1) tie_last = (g == 1);
      chk("issue_addr", 32'(mem.addr), 32'(m_addr[g]));
      chk("issue_dwrite", mem.dwrite, m_dw[g]);
      chk("issue_rw", 32'(mem.rw), 32'(m_rw[g]));
      if (ctl_mode == 0) d = ctl_d;
      else begin
        d = $urandom_range(9);
        d = (d <= 5) ? 1 : (d == 6) ? 2 : (d == 7) ? 3 : (d == 8) ? 15 : 0;
      end
      infl = 1; infl_p = g; s_cyc = cyc; exp_err = (d == 0);
      ack_at  = (d > 0) ? cyc + d : -1;
      oack_at = (d > 0) ? cyc + d + 1 : cyc + 16;
    end else if (infl && cyc > s_cyc && cyc < oack_at) begin
      chk("hold_addr", 32'(mem.addr), 32'(m_addr[infl_p]));
      chk("hold_dwrite", mem.dwrite, m_dw[infl_p]);
      chk("hold_rw", 32'(mem.rw), 32'(m_rw[infl_p]));
    end
    eack = infl && (cyc == oack_at);
    if (eack && exp_err) exp_dread[infl_p] = '0;
    o_ack[0] = cpu.ack; o_ack[1] = wb.ack;
    o_err[0] = cpu.err; o_err[1] = wb.err;
    o_ovf[0] = cpu.ovf; o_ovf[1] = wb.ovf;
    o_dr[0]  = cpu.dread; o_dr[1] = wb.dread;
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("ack%0d", p), 32'(o_ack[p]), 32'(eack && infl_p == p));
      chk($sformatf("err%0d", p), 32'(o_err[p]), 32'(eack && infl_p == p && exp_err));
      chk($sformatf("ovf%0d", p), 32'(o_ovf[p]), 32'(exp_ovf[p]));
      chk($sformatf("dread%0d", p), o_dr[p], exp_dread[p]);
      if (o_ack[p]) obs_ack[p] = cyc;
      if (o_err[p]) obs_err[p] = cyc;
    end
    if (eack) begin m_pend[infl_p] = 0; infl = 0; last_ack = cyc; end
    wait_cyc = infl && cyc > s_cyc && cyc < oack_at;
    ackv = 0;
    if (infl && cyc == ack_at) begin
      ackv = 1;
      exp_dread[infl_p] = mem_arr[m_addr[infl_p]];
      if (mem.rw) begin wr_pend = 1; wr_a = mem.addr; wr_d = mem.dwrite; end
    end else if (noise && !wait_cyc && $urandom_range(3) == 0) begin
      ackv = 1;
    end
    mem.ack = ackv;
    if (restrobe0 && cpu.ack) begin
      set_req(0, rs_addr, 32'h0, 1'b0); restrobe0 = 0;
    end
    for (int p = 0; p < 2; p++) begin
      exp_ovf[p] = r_stb[p] && m_pend[p];
      if (r_stb[p] && !m_pend[p]) begin
        m_pend[p] = 1; m_acc[p] = cyc;
        m_addr[p] = r_addr[p]; m_dw[p] = r_dw[p]; m_rw[p] = r_rw[p];
      end
    end
    cpu.stb = r_stb[0]; cpu.addr = r_addr[0]; cpu.dwrite = r_dw[0]; cpu.rw = r_rw[0];
    wb.stb  = r_stb[1]; wb.addr  = r_addr[1]; wb.dwrite  = r_dw[1]; wb.rw  = r_rw[1];
    r_stb[0] = 0; r_stb[1] = 0;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem_arr[i] = $urandom;
    mem_arr[12'h004] = 32'hDEADBEEF;
    for (int p = 0; p < 2; p++) begin r_addr[p] = '0; r_dw[p] = '0; r_rw[p] = 0; end
    cpu.stb = 0; cpu.addr = '0; cpu.dwrite = '0; cpu.rw = 0;
    wb.stb  = 0; wb.addr  = '0; wb.dwrite  = '0; wb.rw  = 0;
    mem.ack = 0; restrobe0 = 0; rs_addr = '0;
    ctl_mode = 0; ctl_d = 1; noise = 0;
    do_reset();

    // single read on CPU port
    set_req(0, 12'h004, 32'h0, 1'b0); step(); t0 = cyc; run(5);
    chk("rd_stb_lat", 32'(obs_stb - t0), 2);
    chk("rd_ack_lat", 32'(obs_ack[0] - t0), 4);
    chk("rd_dread", cpu.dread, 32'hDEADBEEF);
    chk("rd_p1_quiet", 32'(obs_ack[1]), 32'hFFFF_FFFF);

    // write on wishbone port, two-cycle controller
    ctl_d = 2;
    set_req(1, 12'h013, 32'h11223344, 1'b1); step(); t0 = cyc; run(7);
    chk("wr_ack_lat", 32'(obs_ack[1] - t0), 5);
    chk("wr_mem", mem_arr[12'h013], 32'h11223344);

    // tie pairs after reset
    do_reset(); ctl_d = 1;
    set_req(0, 12'h020, 32'h0, 1'b0); set_req(1, 12'h024, 32'h0, 1'b0); step(); t0 = cyc; run(12);
    chk("tie1_p0", 32'(obs_ack[0] - t0), 4);
    chk("tie1_p1", 32'(obs_ack[1] - t0), 8);
    set_req(0, 12'h028, 32'h0, 1'b0); set_req(1, 12'h02C, 32'h0, 1'b0); step(); t0 = cyc; run(12);
    chk("tie2_p1", 32'(obs_ack[1] - t0), 4);
    chk("tie2_p0", 32'(obs_ack[0] - t0), 8);

    // overflow on re-strobe while pending
    set_req(0, 12'h030, 32'h0, 1'b0); step();
    set_req(0, 12'h034, 32'h0, 1'b0); step(); run(8);
    chk("ovf_dread", cpu.dread, mem_arr[12'h030]);

    // re-strobe in the ack cycle is accepted
    restrobe0 = 1; rs_addr = 12'h038;
    set_req(0, 12'h03C, 32'h0, 1'b0); step(); t0 = cyc; run(10);
    chk("restrobe_lat", 32'(obs_ack[0] - t0), 8);
    chk("restrobe_dread", cpu.dread, mem_arr[12'h038]);

    // controller never acks
    ctl_d = 0;
    set_req(0, 12'h040, 32'h0, 1'b0); step(); run(20);
    chk("to_lat", 32'(obs_ack[0] - obs_stb), 16);
    chk("to_err", 32'(obs_err[0]), 32'(obs_ack[0]));
    chk("to_dread", cpu.dread, 0);
    ctl_d = 1;
    set_req(1, 12'h044, 32'h0, 1'b0); step(); t0 = cyc; run(5);
    chk("post_to_lat", 32'(obs_ack[1] - t0), 4);

    // ack on the last wait cycle still wins over timeout
    ctl_d = 15;
    set_req(0, 12'h048, 32'hCAFEF00D, 1'b1); step(); run(22);
    chk("late_lat", 32'(obs_ack[0] - obs_stb), 16);
    chk("late_noerr", 32'(obs_err[0] < obs_stb), 1);
    chk("late_mem", mem_arr[12'h048], 32'hCAFEF00D);

    // randomized traffic with random latency and stray acks
    ctl_mode = 1; noise = 1;
    repeat (600) begin
      for (int p = 0; p < 2; p++)
        if ($urandom_range(3) == 0)
          set_req(p, AW'(12'h100 + 4 * $urandom_range(15)), $urandom, 1'($urandom_range(1)));
      step();
    end
    ctl_mode = 0; ctl_d = 1; noise = 0;
    run(45);

    // reset in WAIT with both pending
    ctl_d = 0;
    set_req(0, 12'h050, 32'h0, 1'b0); set_req(1, 12'h054, 32'h0, 1'b0); step(); run(4);
    do_reset(); run(20);
    chk("rstw_no_ack0", 32'(obs_ack[0]), 32'hFFFF_FFFF);
    chk("rstw_no_ack1", 32'(obs_ack[1]), 32'hFFFF_FFFF);
    ctl_d = 1;
    set_req(1, 12'h058, 32'h0, 1'b0); step(); t0 = cyc; run(5);
    chk("rstw_fresh_lat", 32'(obs_ack[1] - t0), 4);
    chk("rstw_fresh_dread", wb.dread, mem_arr[12'h058]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
